// File: rtl/usb_crc_pkg.sv
// USB CRC constants, mode type and a bit-serial reference CRC.
// Shared by the serialiser, its LFSRs and the bench.
package usb_crc_pkg;

  typedef enum logic {
    CRC5  = 1'b0,
    CRC16 = 1'b1
  } crc_mode_t;

  localparam logic [4:0]  CRC5_POLY        = 5'h05;
  localparam logic [15:0] CRC16_POLY       = 16'h8005;
  localparam logic [4:0]  CRC5_RESIDUAL    = 5'h0C;
  localparam logic [15:0] CRC16_RESIDUAL   = 16'h800D;
  localparam int          DEFAULT_PID_BITS = 8;
  localparam int          MAX_REF_BITS     = 128;

  // Complemented CRC over bits[len-1:0], bit 0 first; CRC5 result sits in [4:0].
  function automatic logic [15:0] crc_ref(input logic [MAX_REF_BITS-1:0] bits,
                                          input int len, input crc_mode_t mode);
    logic [15:0] crc;
    logic        fb;
    crc = 16'hFFFF;
    for (int i = 0; i < MAX_REF_BITS; i++) begin
      if (i < len) begin
        if (mode == CRC16) begin
          fb  = bits[i] ^ crc[15];
          crc = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end else begin
          fb  = bits[i] ^ crc[4];
          crc = {11'h000, crc[3:0], 1'b0} ^ (fb ? {11'h000, CRC5_POLY} : 16'h0000);
        end
      end
    end
    return (mode == CRC16) ? ~crc : {11'h000, ~crc[4:0]};
  endfunction

endpackage

// File: rtl/usb_crc_append_if.sv
// Packet-in / bit-out handshake bundle of the CRC serialiser.
// master = protocol handler plus bit stuffer side, slave = serialiser.
interface usb_crc_append_if #(
  parameter int MAX_BITS = 100,
  parameter int LW       = $clog2(MAX_BITS + 1)
);
  logic                pkt_valid;
  logic                pkt_ready;
  logic [MAX_BITS-1:0] pkt_in;
  logic [LW-1:0]       pkt_len;
  logic                crc_mode;
  logic                crc_en;
  logic                out_bit;
  logic                out_valid;
  logic                out_ready;
  logic                pkt_done;

  modport master (
    output pkt_valid, pkt_in, pkt_len, crc_mode, crc_en, out_ready,
    input  pkt_ready, out_bit, out_valid, pkt_done
  );

  modport slave (
    input  pkt_valid, pkt_in, pkt_len, crc_mode, crc_en, out_ready,
    output pkt_ready, out_bit, out_valid, pkt_done
  );
endinterface

// File: rtl/usb_crc_lfsr.sv
// Serial CRC LFSR, preset to all ones on clear, one step per asserted step.
// Single-cycle update; holds whenever step is low.
module usb_crc_lfsr #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             step,
  input  logic             din,
  output logic [WIDTH-1:0] crc_q
);

  logic [WIDTH-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = din ^ r_crc[WIDTH-1];
  assign crc_q = r_crc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= '1;
    end else if (clear) begin
      r_crc <= '1;
    end else if (step) begin
      r_crc <= {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/usb_crc_append.sv
// Streams a parallel USB packet LSB-first and appends the complemented CRC5/CRC16.
// First bit one cycle after acceptance; every out_ready-low cycle holds all state.
module usb_crc_append
  import usb_crc_pkg::*;
#(
  parameter int  MAX_BITS = 100,
  parameter int  PID_BITS = DEFAULT_PID_BITS,
  localparam int LW       = $clog2(MAX_BITS + 1)
) (
  input logic             clock,
  input logic             reset_n,
  usb_crc_append_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_CRC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          r_state;
  logic [MAX_BITS-1:0] r_shift;
  logic [LW-1:0]       r_len;
  logic [LW-1:0]       r_cnt;
  logic [3:0]          r_crc_idx;
  crc_mode_t           r_mode;
  logic                r_en;

  logic                w_accept;
  logic                w_out_valid;
  logic                w_xfer;
  logic                w_step;
  logic                w_last_data;
  logic                w_last_crc;
  logic [LW-1:0]       w_len_clamp;
  logic [4:0]          w_crc5;
  logic [15:0]         w_crc16;
  logic [4:0]          w_crc5_sh;
  logic [15:0]         w_crc16_sh;
  logic                w_crc_bit;

  assign w_accept    = bus.pkt_valid && (r_state == S_IDLE);
  assign w_out_valid = (r_state == S_DATA) || (r_state == S_CRC);
  assign w_xfer      = w_out_valid && bus.out_ready;
  assign w_len_clamp = (32'(bus.pkt_len) > MAX_BITS) ? LW'(MAX_BITS) : bus.pkt_len;

  // PID bits go on the wire but never into the CRC.
  assign w_step      = w_xfer && (r_state == S_DATA) && (32'(r_cnt) >= PID_BITS);
  assign w_last_data = (r_cnt == r_len - LW'(1));
  assign w_last_crc  = (r_mode == CRC16) ? (r_crc_idx == 4'd15) : (r_crc_idx == 4'd4);

  usb_crc_lfsr #(
    .WIDTH (5),
    .POLY  (CRC5_POLY)
  ) u_crc5 (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_accept),
    .step    (w_step),
    .din     (r_shift[0]),
    .crc_q   (w_crc5)
  );

  usb_crc_lfsr #(
    .WIDTH (16),
    .POLY  (CRC16_POLY)
  ) u_crc16 (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_accept),
    .step    (w_step),
    .din     (r_shift[0]),
    .crc_q   (w_crc16)
  );

  // Highest-order CRC bit leaves first, so shift the selected bit up to the MSB.
  assign w_crc5_sh  = w_crc5 << r_crc_idx;
  assign w_crc16_sh = w_crc16 << r_crc_idx;
  assign w_crc_bit  = ~((r_mode == CRC16) ? w_crc16_sh[15] : w_crc5_sh[4]);

  assign bus.pkt_ready = (r_state == S_IDLE);
  assign bus.out_valid = w_out_valid;
  assign bus.pkt_done  = (r_state == S_DONE);
  assign bus.out_bit   = (r_state == S_DATA) ? r_shift[0] :
                         (r_state == S_CRC)  ? w_crc_bit  : 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_crc_idx <= '0;
      r_mode    <= CRC5;
      r_en      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift   <= bus.pkt_in;
            r_len     <= w_len_clamp;
            r_mode    <= crc_mode_t'(bus.crc_mode);
            r_en      <= bus.crc_en;
            r_cnt     <= '0;
            r_crc_idx <= '0;
            r_state   <= (w_len_clamp == '0) ? S_DONE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + LW'(1);
            if (w_last_data) begin
              r_state <= r_en ? S_CRC : S_DONE;
            end
          end
        end
        S_CRC: begin
          if (w_xfer) begin
            r_crc_idx <= r_crc_idx + 4'd1;
            if (w_last_crc) begin
              r_state <= S_DONE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
